// File: rtl/shift_sequencer.sv
// Multi-pass controller for a 5-bit barrel shifter (ARM register shifts, 0..255); 1 + ceil(rem/STEP_MAX) cycles, result held until rsp_ready.
// Carry-out logic only with SHIFT_SEQ_CARRY_EN defined; otherwise rsp_carry is 0 and req_carry is ignored.
module shift_sequencer #(
    parameter int AMT_W    = 8,
    parameter int STEP_MAX = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_data,
    input  logic [AMT_W-1:0] req_amount,
    input  logic [1:0]       req_type,
    input  logic             req_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             rsp_carry,
    output logic             busy,
    output logic [31:0]      sh_in,
    output logic [4:0]       sh_amount,
    output logic [1:0]       sh_type,
    input  logic [31:0]      sh_out
);
    localparam logic [1:0] LSL = 2'b00;
    localparam logic [1:0] LSR = 2'b01;
    localparam logic [1:0] ASR = 2'b10;
    localparam logic [1:0] ROR = 2'b11;
    localparam logic [AMT_W-1:0] STEP_LIM = AMT_W'(STEP_MAX);
    localparam logic [AMT_W-1:0] AMT_32   = AMT_W'(32);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [31:0]      acc, acc_nxt;
    logic [1:0]       typ, typ_nxt;
    logic [AMT_W-1:0] rem, rem_nxt;
    logic [4:0]       step;
    logic             accept;

    assign step      = (rem > STEP_LIM) ? 5'(STEP_MAX) : rem[4:0];
    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign rsp_data  = acc;
    assign sh_in     = acc;
    assign sh_type   = typ;
    assign sh_amount = (state == SHIFT) ? step : 5'd0;

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        typ_nxt   = typ;
        rem_nxt   = rem;
        case (state)
            IDLE: begin
                if (accept) begin
                    acc_nxt   = req_data;
                    typ_nxt   = req_type;
                    rem_nxt   = '0;
                    state_nxt = DONE;
                    if (req_amount != '0) begin
                        if (req_type == ROR) begin
                            // Rotation is modulo 32; a multiple of 32 leaves data untouched.
                            if (req_amount[4:0] != 5'd0) begin
                                rem_nxt   = AMT_W'(req_amount[4:0]);
                                state_nxt = SHIFT;
                            end
                        end else if (req_type == ASR) begin
                            if (req_amount >= AMT_32) begin
                                acc_nxt = {32{req_data[31]}};
                            end else begin
                                rem_nxt   = req_amount;
                                state_nxt = SHIFT;
                            end
                        end else if (req_amount >= AMT_32) begin
                            acc_nxt = 32'd0;
                        end else begin
                            rem_nxt   = req_amount;
                            state_nxt = SHIFT;
                        end
                    end
                end
            end
            SHIFT: begin
                acc_nxt = sh_out;
                rem_nxt = rem - AMT_W'(step);
                if (rem == AMT_W'(step)) state_nxt = DONE;
            end
            DONE: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            acc   <= 32'd0;
            typ   <= 2'b00;
            rem   <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            typ   <= typ_nxt;
            rem   <= rem_nxt;
        end
    end

`ifdef SHIFT_SEQ_CARRY_EN
    logic       carry, carry_nxt;
    logic [4:0] lsl_idx;

    // 0 - step wraps to 32 - step for step in 1..31.
    assign lsl_idx = 5'd0 - step;

    always_comb begin
        carry_nxt = carry;
        if (accept) begin
            carry_nxt = req_carry;
            if (req_amount != '0) begin
                if (req_type == ROR) begin
                    if (req_amount[4:0] == 5'd0) carry_nxt = req_data[31];
                end else if (req_type == ASR) begin
                    if (req_amount >= AMT_32) carry_nxt = req_data[31];
                end else if (req_amount == AMT_32) begin
                    carry_nxt = (req_type == LSL) ? req_data[0] : req_data[31];
                end else if (req_amount > AMT_32) begin
                    carry_nxt = 1'b0;
                end
            end
        end else if (state == SHIFT) begin
            case (typ)
                LSL:     carry_nxt = acc[lsl_idx];
                LSR,
                ASR:     carry_nxt = acc[step - 5'd1];
                default: carry_nxt = sh_out[31];
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) carry <= 1'b0;
        else       carry <= carry_nxt;
    end

    assign rsp_carry = carry;
`else
    logic unused_carry;
    assign unused_carry = req_carry;
    assign rsp_carry    = 1'b0;
`endif
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: two instances (STEP_MAX 31 and 7) driven by a behavioural barrel shifter.
module tb_shift_sequencer;
`ifdef SHIFT_SEQ_CARRY_EN
    localparam logic CE = 1'b1;
`else
    localparam logic CE = 1'b0;
`endif
    localparam logic [1:0] LSL = 2'b00, LSR = 2'b01, ASR = 2'b10, ROR = 2'b11;

    logic clk, reset, rsp_ready;
    logic req_valid, req_ready, req_carry, rsp_valid, rsp_carry, busy;
    logic [31:0] req_data, rsp_data, sh_in, sh_out;
    logic [7:0]  req_amount;
    logic [1:0]  req_type, sh_type;
    logic [4:0]  sh_amount;
    logic req_valid_7, req_ready_7, req_carry_7, rsp_valid_7, rsp_carry_7, busy_7;
    logic [31:0] req_data_7, rsp_data_7, sh_in_7, sh_out_7;
    logic [7:0]  req_amount_7;
    logic [1:0]  req_type_7, sh_type_7;
    logic [4:0]  sh_amount_7;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic ok);
        n_chk++;
        if (ok !== 1'b1) begin
            n_fail++;
            $error("FAIL %s", tag);
        end
    endtask

    function automatic logic [31:0] barrel(input logic [31:0] d, input logic [4:0] a, input logic [1:0] t);
        case (t)
            LSL:     return d << a;
            LSR:     return d >> a;
            ASR:     return 32'($signed(d) >>> a);
            default: return (d >> a) | (d << (6'd32 - {1'b0, a}));
        endcase
    endfunction

    assign sh_out   = barrel(sh_in, sh_amount, sh_type);
    assign sh_out_7 = barrel(sh_in_7, sh_amount_7, sh_type_7);

    shift_sequencer #(.AMT_W(8), .STEP_MAX(31)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .req_amount(req_amount), .req_type(req_type), .req_carry(req_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_carry(rsp_carry), .busy(busy),
        .sh_in(sh_in), .sh_amount(sh_amount), .sh_type(sh_type), .sh_out(sh_out)
    );

    shift_sequencer #(.AMT_W(8), .STEP_MAX(7)) dut7 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_7), .req_ready(req_ready_7), .req_data(req_data_7),
        .req_amount(req_amount_7), .req_type(req_type_7), .req_carry(req_carry_7),
        .rsp_valid(rsp_valid_7), .rsp_ready(rsp_ready), .rsp_data(rsp_data_7),
        .rsp_carry(rsp_carry_7), .busy(busy_7),
        .sh_in(sh_in_7), .sh_amount(sh_amount_7), .sh_type(sh_type_7), .sh_out(sh_out_7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // Issue one request, count cycles until rsp_valid and check result, carry, latency and first-pass amount.
    task automatic run_op(input string tag, input logic s7, input logic [31:0] d, input logic [7:0] a,
                          input logic [1:0] t, input logic c, input logic [31:0] ed, input logic ec,
                          input int el, input logic [4:0] esh);
        int lat;
        logic [4:0] sh1;
        logic v;
        logic [31:0] rd;
        logic rc;
        @(negedge clk);
        if (s7) begin
            req_valid_7 = 1'b1; req_data_7 = d; req_amount_7 = a; req_type_7 = t; req_carry_7 = c;
        end else begin
            req_valid = 1'b1; req_data = d; req_amount = a; req_type = t; req_carry = c;
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_valid_7 = 1'b0;
        lat = 1;
        sh1 = s7 ? sh_amount_7 : sh_amount;
        v = s7 ? rsp_valid_7 : rsp_valid;
        while (!v && lat < 40) begin
            @(negedge clk);
            lat++;
            v = s7 ? rsp_valid_7 : rsp_valid;
        end
        rd = s7 ? rsp_data_7 : rsp_data;
        rc = s7 ? rsp_carry_7 : rsp_carry;
        check($sformatf("%s_lat", tag), lat == el);
        check($sformatf("%s_data", tag), rd === ed);
        check($sformatf("%s_carry", tag), rc === (CE & ec));
        check($sformatf("%s_sh1", tag), sh1 === esh);
    endtask

    initial begin
        logic seen;
        reset = 1'b1; rsp_ready = 1'b1;
        req_valid = 0; req_data = 0; req_amount = 0; req_type = 0; req_carry = 0;
        req_valid_7 = 0; req_data_7 = 0; req_amount_7 = 0; req_type_7 = 0; req_carry_7 = 0;
        @(negedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready === 1'b0);
        check("rst_rsp_valid", rsp_valid === 1'b0);
        check("rst_rsp_data", rsp_data === 32'h0);
        check("rst_rsp_carry", rsp_carry === 1'b0);
        check("rst_busy", busy === 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_req_ready", req_ready === 1'b1);

        run_op("lsl4",    1'b0, 32'h0000_0001, 8'd4,  LSL, 1'b0, 32'h0000_0010, 1'b0, 2, 5'd4);
        run_op("asr40",   1'b0, 32'h8000_0000, 8'd40, ASR, 1'b0, 32'hFFFF_FFFF, 1'b1, 1, 5'd0);
        run_op("ror36",   1'b0, 32'h0000_00F1, 8'd36, ROR, 1'b1, 32'h1000_000F, 1'b0, 2, 5'd4);
        run_op("lsl32",   1'b0, 32'h0000_0001, 8'd32, LSL, 1'b0, 32'h0000_0000, 1'b1, 1, 5'd0);
        run_op("lsr0",    1'b0, 32'hFFFF_FFFF, 8'd0,  LSR, 1'b1, 32'hFFFF_FFFF, 1'b1, 1, 5'd0);
        run_op("lsr33",   1'b0, 32'h8000_0000, 8'd33, LSR, 1'b1, 32'h0000_0000, 1'b0, 1, 5'd0);
        run_op("lsr32",   1'b0, 32'h8000_0000, 8'd32, LSR, 1'b0, 32'h0000_0000, 1'b1, 1, 5'd0);
        run_op("ror32",   1'b0, 32'h8000_0001, 8'd32, ROR, 1'b0, 32'h8000_0001, 1'b1, 1, 5'd0);
        run_op("asr5",    1'b0, 32'h8000_0010, 8'd5,  ASR, 1'b0, 32'hFC00_0000, 1'b1, 2, 5'd5);
        run_op("lsr31",   1'b0, 32'hC000_0000, 8'd31, LSR, 1'b0, 32'h0000_0001, 1'b1, 2, 5'd31);
        run_op("asr200",  1'b0, 32'h7FFF_FFFF, 8'd200, ASR, 1'b1, 32'h0000_0000, 1'b0, 1, 5'd0);
        run_op("s7_lsr20", 1'b1, 32'hFFFF_FFFF, 8'd20, LSR, 1'b0, 32'h0000_0FFF, 1'b1, 4, 5'd7);
        run_op("s7_lsl31", 1'b1, 32'h0000_0001, 8'd31, LSL, 1'b1, 32'h8000_0000, 1'b0, 6, 5'd7);

        // Hold the response under backpressure while a competing request is offered.
        rsp_ready = 1'b0;
        run_op("bp", 1'b0, 32'h0000_0005, 8'd1, LSL, 1'b0, 32'h0000_000A, 1'b0, 2, 5'd1);
        req_valid = 1'b1; req_data = 32'hDEAD_BEEF; req_amount = 8'd3; req_type = LSR;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", rsp_valid === 1'b1);
            check("bp_rsp_data", rsp_data === 32'h0000_000A);
            check("bp_req_ready", req_ready === 1'b0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", rsp_valid === 1'b0);
        check("bp_release_ready", req_ready === 1'b1);
        check("bp_release_busy", busy === 1'b0);

        // Reset while a response is pending.
        rsp_ready = 1'b0;
        run_op("rd", 1'b0, 32'h1234_5678, 8'd0, LSL, 1'b1, 32'h1234_5678, 1'b1, 1, 5'd0);
        reset = 1'b1;
        #1;
        check("rd_rsp_valid", rsp_valid === 1'b0);
        check("rd_rsp_data", rsp_data === 32'h0);
        check("rd_busy", busy === 1'b0);
        @(negedge clk);
        reset = 1'b0;
        rsp_ready = 1'b1;

        // Reset in the middle of a multi-pass shift.
        @(negedge clk);
        req_valid_7 = 1'b1; req_data_7 = 32'h0000_0001; req_amount_7 = 8'd31; req_type_7 = LSL;
        @(negedge clk);
        req_valid_7 = 1'b0;
        @(negedge clk);
        check("rs_busy_before", busy_7 === 1'b1);
        check("rs_valid_before", rsp_valid_7 === 1'b0);
        reset = 1'b1;
        #1;
        check("rs_busy_after", busy_7 === 1'b0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen = seen | rsp_valid_7;
        end
        check("rs_no_response", seen === 1'b0);
        run_op("rs_recover", 1'b1, 32'h0000_0001, 8'd31, LSL, 1'b0, 32'h8000_0000, 1'b0, 6, 5'd7);
        run_op("post_rst",   1'b0, 32'h0000_0001, 8'd4,  LSL, 1'b0, 32'h0000_0010, 1'b0, 2, 5'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
